// File: rtl/counter_pkg.sv
// Shared definitions for the counter lab datapath: FSM state encoding.
package counter_pkg;

    // Encoding is fixed so downstream display/checker logic can decode it.
    // The value 2'd3 is unused and recovers to S_IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage : counter_pkg

// File: rtl/mode_counter.sv
// Programmable terminal-count counter. Counts 0..lim_q after an accepted
// start, flags terminal count, then either stops in DONE (one-shot) or
// wraps to 0 (auto-reload). Soft clear and freeze come from the upstream
// selector stage.
module mode_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             freeze,
    input  logic             start,
    input  logic             auto,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] lim_q,   lim_d;

    logic at_limit;

    assign at_limit = (count_q == lim_q);

    // Next-state, next-count and limit-latch logic; priority clr > freeze > run.
    always_comb begin
        // NOTE: every target gets a hold default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_d = state_q;
        count_d = count_q;
        lim_d   = lim_q;

        if (clr) begin
            // Soft clear: back to IDLE with count zeroed, limit kept.
            state_d = S_IDLE;
            count_d = '0;
        end else if (!freeze) begin
            // Frozen cycles fall through with everything held; a start seen
            // while frozen is simply never acted on.
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        lim_d   = limit;
                        count_d = '0;
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (at_limit) begin
                        // auto is only looked at here, so a mid-run change
                        // takes effect at the next terminal count.
                        if (auto) begin
                            count_d = '0;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        // count never exceeds lim_q, so this cannot wrap.
                        count_d = count_q + 1'b1;
                    end
                end
                default: begin
                    // Unused encoding recovers to IDLE with a clean count.
                    state_d = S_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            lim_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            lim_q   <= lim_d;
        end
    end

    assign count = count_q;
    assign busy  = (state_q == S_RUN);
    assign done  = (state_q == S_DONE);
    // Terminal count is combinational so it lines up with the cycle in which
    // count shows lim_q; freeze masks it so a held run never re-flags.
    assign tc    = (state_q == S_RUN) & at_limit & ~freeze;

endmodule : mode_counter
